// File: rtl/mem_arbiter_pkg.sv
// Shared CPU definitions used by the memory arbiter and its store queue:
// the "no ROB tag" value, memory access-size codes, arbiter FSM encoding
// and the store-queue entry layout.
package mem_arbiter_pkg;

    localparam logic [5:0] ROB_NONE = 6'b010000;

    // Access size codes carried on st_type / ld_type / mem_type.
    localparam logic [2:0] MT_SB = 3'b000;
    localparam logic [2:0] MT_SH = 3'b001;
    localparam logic [2:0] MT_SW = 3'b010;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_STORE = 2'd1,
        ARB_LOAD  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic [5:0]  rob;
        logic [2:0]  typ;
        logic [31:0] addr;
        logic [31:0] data;
    } st_entry_t;

endpackage

// File: rtl/store_queue.sv
// Store queue: DEPTH-entry FIFO of stores waiting for ROB retirement.
// Ports:
//   clock, reset                 - clock, async active-high reset
//   enq_*                        - store from the store RS; enq_ready = !full
//   commit_valid, commit_rob     - ROB retires the store with this tag
//   flush                        - drop every uncommitted entry
//   deq                          - pop the head (memory write finished)
//   head_*                       - head entry state and payload
//   chk_addr, conflict           - word-address match against any valid entry
module store_queue
    import mem_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enq_valid,
    input  logic [5:0]  enq_rob,
    input  logic [2:0]  enq_type,
    input  logic [31:0] enq_addr,
    input  logic [31:0] enq_data,
    output logic        enq_ready,
    input  logic        commit_valid,
    input  logic [5:0]  commit_rob,
    input  logic        flush,
    input  logic        deq,
    output logic        head_valid,
    output logic        head_committed,
    output logic [2:0]  head_type,
    output logic [31:0] head_addr,
    output logic [31:0] head_data,
    input  logic [31:0] chk_addr,
    output logic        conflict
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0]      vld, cmt, cmt_nx;
    st_entry_t [DEPTH-1:0] ent;
    logic [PW-1:0]         head, tail;
    logic [CW-1:0]         count, n_cmt;
    logic                  do_enq, new_cmt;

    always_comb begin
        enq_ready = (count != CW'(DEPTH));
        // A store arriving in the flush cycle is on the wrong path; drop it.
        do_enq    = enq_valid && enq_ready && !flush;
        new_cmt   = commit_valid && (enq_rob == commit_rob);
        conflict  = 1'b0;
        n_cmt     = '0;
        cmt_nx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cmt_nx[i] = vld[i] && (cmt[i] || (commit_valid && ent[i].rob == commit_rob));
            if (cmt_nx[i])
                n_cmt += CW'(1);
            if (vld[i] && ent[i].addr[31:2] == chk_addr[31:2])
                conflict = 1'b1;
        end
        head_valid     = vld[head];
        head_committed = cmt[head];
        head_type      = ent[head].typ;
        head_addr      = ent[head].addr;
        head_data      = ent[head].data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld   <= '0;
            cmt   <= '0;
            ent   <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            cmt <= cmt_nx;
            if (flush) begin
                // Committed entries always form a contiguous run from head,
                // so the new tail is simply head + number committed.
                vld   <= cmt_nx;
                tail  <= head + PW'(n_cmt);
                count <= n_cmt - CW'(deq);
            end else begin
                if (do_enq) begin
                    vld[tail] <= 1'b1;
                    cmt[tail] <= new_cmt;
                    ent[tail] <= '{rob: enq_rob, typ: enq_type, addr: enq_addr, data: enq_data};
                end
                tail  <= tail + PW'(do_enq);
                count <= count + CW'(do_enq) - CW'(deq);
            end
            if (deq) begin
                vld[head] <= 1'b0;
                cmt[head] <= 1'b0;
                head      <= head + PW'(1);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Memory arbiter: single-port memory shared by retired stores (from the
// store queue) and loads. Committed stores have priority; a load that hits
// the word of any queued store waits until that store has drained.
// Ports:
//   clock, reset                        - clock, async active-high reset
//   st_*  / st_ready                    - store from store RS
//   ld_*  / ld_ready                    - load request, ld_ready pulses on accept
//   commit_valid, commit_rob            - store retirement from the ROB
//   flush                               - mispredict
//   mem_req/we/type/addr/wdata, mem_ack, mem_rdata - memory port
//   ld_done, ld_rob_out, ld_data        - load result to the CDB
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int         DEPTH       = 4,
    parameter logic [5:0] INVALID_ROB = ROB_NONE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [5:0]  st_rob,
    input  logic [2:0]  st_type,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_ready,
    input  logic        ld_valid,
    input  logic [5:0]  ld_rob,
    input  logic [2:0]  ld_type,
    input  logic [31:0] ld_addr,
    output logic        ld_ready,
    input  logic        commit_valid,
    input  logic [5:0]  commit_rob,
    input  logic        flush,
    output logic        mem_req,
    output logic        mem_we,
    output logic [2:0]  mem_type,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        ld_done,
    output logic [5:0]  ld_rob_out,
    output logic [31:0] ld_data
);
    arb_state_t  state, state_nx;
    logic [5:0]  ld_rob_q;
    logic [2:0]  ld_type_q;
    logic [31:0] ld_addr_q, rdata_q;
    logic        ld_kill;
    logic        hd_vld, hd_cmt, conflict;
    logic [2:0]  hd_type;
    logic [31:0] hd_addr, hd_data;
    logic        sq_deq;

    assign sq_deq = (state == ARB_STORE) && mem_ack;

    store_queue #(.DEPTH(DEPTH)) u_sq (
        .clock          (clock),
        .reset          (reset),
        .enq_valid      (st_valid),
        .enq_rob        (st_rob),
        .enq_type       (st_type),
        .enq_addr       (st_addr),
        .enq_data       (st_data),
        .enq_ready      (st_ready),
        .commit_valid   (commit_valid),
        .commit_rob     (commit_rob),
        .flush          (flush),
        .deq            (sq_deq),
        .head_valid     (hd_vld),
        .head_committed (hd_cmt),
        .head_type      (hd_type),
        .head_addr      (hd_addr),
        .head_data      (hd_data),
        .chk_addr       (ld_addr),
        .conflict       (conflict)
    );

    always_comb begin
        state_nx  = state;
        ld_ready  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_type  = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            ARB_IDLE: begin
                if (hd_vld && hd_cmt) begin
                    state_nx = ARB_STORE;
                end else if (ld_valid && !conflict && !flush) begin
                    state_nx = ARB_LOAD;
                    ld_ready = 1'b1;
                end
            end
            ARB_STORE: begin
                // Head is committed, so neither flush nor enqueue can move it.
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_type  = hd_type;
                mem_addr  = hd_addr;
                mem_wdata = hd_data;
                if (mem_ack)
                    state_nx = ARB_IDLE;
            end
            ARB_LOAD: begin
                mem_req  = 1'b1;
                mem_type = ld_type_q;
                mem_addr = ld_addr_q;
                if (mem_ack)
                    state_nx = ARB_RESP;
            end
            ARB_RESP: state_nx = ARB_IDLE;
            default:  state_nx = ARB_IDLE;
        endcase
        ld_done    = (state == ARB_RESP) && !ld_kill && !flush;
        ld_rob_out = ld_done ? ld_rob_q : INVALID_ROB;
        ld_data    = ld_done ? rdata_q : '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ARB_IDLE;
            ld_rob_q  <= INVALID_ROB;
            ld_type_q <= '0;
            ld_addr_q <= '0;
            rdata_q   <= '0;
            ld_kill   <= 1'b0;
        end else begin
            state <= state_nx;
            if (ld_ready) begin
                ld_rob_q  <= ld_rob;
                ld_type_q <= ld_type;
                ld_addr_q <= ld_addr;
                ld_kill   <= 1'b0;
            end else if (flush && (state == ARB_LOAD || state == ARB_RESP)) begin
                // Memory access still completes; only the result is dropped.
                ld_kill <= 1'b1;
            end
            if (state == ARB_LOAD && mem_ack)
                rdata_q <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam logic [5:0] NOROB = 6'b010000;

    logic        clock, reset;
    logic        st_valid, st_ready;
    logic [5:0]  st_rob;
    logic [2:0]  st_type;
    logic [31:0] st_addr, st_data;
    logic        ld_valid, ld_ready;
    logic [5:0]  ld_rob;
    logic [2:0]  ld_type;
    logic [31:0] ld_addr;
    logic        commit_valid;
    logic [5:0]  commit_rob;
    logic        flush;
    logic        mem_req, mem_we, mem_ack;
    logic [2:0]  mem_type;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        ld_done;
    logic [5:0]  ld_rob_out;
    logic [31:0] ld_data;

    int checks = 0;
    int fails  = 0;

    mem_arbiter #(.DEPTH(4), .INVALID_ROB(6'b010000)) dut (
        .clock(clock), .reset(reset),
        .st_valid(st_valid), .st_rob(st_rob), .st_type(st_type),
        .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_rob(ld_rob), .ld_type(ld_type),
        .ld_addr(ld_addr), .ld_ready(ld_ready),
        .commit_valid(commit_valid), .commit_rob(commit_rob), .flush(flush),
        .mem_req(mem_req), .mem_we(mem_we), .mem_type(mem_type),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ld_done(ld_done), .ld_rob_out(ld_rob_out), .ld_data(ld_data)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [5:0] rob, input logic [2:0] typ,
                        input logic [31:0] addr, input logic [31:0] data);
        st_valid = 1'b1; st_rob = rob; st_type = typ; st_addr = addr; st_data = data;
        tick;
        st_valid = 1'b0;
    endtask

    task automatic commit(input logic [5:0] rob);
        commit_valid = 1'b1; commit_rob = rob;
        tick;
        commit_valid = 1'b0;
    endtask

    task automatic issue_load(input string tag, input logic [5:0] rob, input logic [31:0] addr);
        ld_valid = 1'b1; ld_rob = rob; ld_type = 3'b010; ld_addr = addr;
        #1;
        chk(tag, ld_ready, 1'b1);
        tick;
        ld_valid = 1'b0;
    endtask

    // Waits for a request, checks its fields every cycle it is held, acks
    // after waitc extra cycles and checks that the request then drops.
    task automatic do_mem(input string tag, input int waitc, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] typ, input logic [31:0] rdata);
        int n = 0;
        while (!mem_req && n < 20) begin
            tick;
            n++;
        end
        if (!mem_req) begin
            chk({tag, "_req_timeout"}, mem_req, 1'b1);
            return;
        end
        for (int k = 0; k <= waitc; k++) begin
            chk({tag, "_req"},   mem_req,   1'b1);
            chk({tag, "_we"},    mem_we,    we);
            chk({tag, "_addr"},  mem_addr,  addr);
            chk({tag, "_wdata"}, mem_wdata, wdata);
            chk({tag, "_type"},  mem_type,  typ);
            if (k == waitc) begin
                mem_ack = 1'b1; mem_rdata = rdata;
            end
            tick;
            mem_ack = 1'b0; mem_rdata = '0;
        end
        chk({tag, "_drop"}, mem_req, 1'b0);
    endtask

    task automatic quiet(input string tag, input int cyc);
        logic seen = 1'b0;
        repeat (cyc) begin
            if (mem_req) seen = 1'b1;
            tick;
        end
        chk(tag, seen, 1'b0);
    endtask

    initial begin
        logic bad;
        reset = 1'b1;
        st_valid = 0; st_rob = 0; st_type = 0; st_addr = 0; st_data = 0;
        ld_valid = 0; ld_rob = 0; ld_type = 0; ld_addr = 0;
        commit_valid = 0; commit_rob = 0; flush = 0; mem_ack = 0; mem_rdata = 0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_st_ready", st_ready,   1'b1);
        chk("rst_mem_req",  mem_req,    1'b0);
        chk("rst_mem_we",   mem_we,     1'b0);
        chk("rst_mem_addr", mem_addr,   32'h0);
        chk("rst_ld_done",  ld_done,    1'b0);
        chk("rst_ld_ready", ld_ready,   1'b0);
        chk("rst_ld_rob",   ld_rob_out, NOROB);
        chk("rst_ld_data",  ld_data,    32'h0);
        reset = 1'b0;
        tick;

        // Committed SW store, ack held off two cycles -> request high 3 cycles.
        push(6'd3, 3'b010, 32'h100, 32'hDEADBEEF);
        commit(6'd3);
        do_mem("t1_st", 2, 1'b1, 32'h100, 32'hDEADBEEF, 3'b010, 32'h0);
        issue_load("t1_empty_ld_ready", 6'd9, 32'h100);
        do_mem("t1_ld", 0, 1'b0, 32'h100, 32'h0, 3'b010, 32'hCAFE0000);
        chk("t1_ld_done", ld_done,    1'b1);
        chk("t1_ld_rob",  ld_rob_out, 6'd9);
        chk("t1_ld_data", ld_data,    32'hCAFE0000);
        tick;
        chk("t1_done_pulse", ld_done,    1'b0);
        chk("t1_rob_idle",   ld_rob_out, NOROB);

        // Load to same word as an uncommitted store must wait.
        push(6'd5, 3'b010, 32'h200, 32'h11112222);
        ld_valid = 1'b1; ld_rob = 6'd6; ld_type = 3'b010; ld_addr = 32'h203;
        bad = 1'b0;
        repeat (3) begin
            #1;
            if (ld_ready || mem_req) bad = 1'b1;
            tick;
        end
        chk("t2_ld_blocked", bad, 1'b0);
        commit(6'd5);
        chk("t2_store_first", ld_ready, 1'b0);
        do_mem("t2_st", 0, 1'b1, 32'h200, 32'h11112222, 3'b010, 32'h0);
        chk("t2_ld_ready", ld_ready, 1'b1);
        tick;
        ld_valid = 1'b0;
        do_mem("t2_ld", 1, 1'b0, 32'h203, 32'h0, 3'b010, 32'h55AA0033);
        chk("t2_ld_done", ld_done,    1'b1);
        chk("t2_ld_rob",  ld_rob_out, 6'd6);
        chk("t2_ld_data", ld_data,    32'h55AA0033);
        tick;

        // Fill the queue; the fifth store is refused.
        for (int i = 0; i < 4; i++)
            push(6'(10 + i), 3'b010, 32'h300 + 32'(4 * i), 32'(i));
        chk("t3_full", st_ready, 1'b0);
        push(6'd14, 3'b010, 32'h310, 32'h99);
        commit(6'd10);
        do_mem("t3_a", 0, 1'b1, 32'h300, 32'h0, 3'b010, 32'h0);
        chk("t3_ready_again", st_ready, 1'b1);
        for (int i = 11; i <= 14; i++)
            commit(6'(i));
        do_mem("t3_b", 0, 1'b1, 32'h304, 32'h1, 3'b010, 32'h0);
        do_mem("t3_c", 0, 1'b1, 32'h308, 32'h2, 3'b010, 32'h0);
        do_mem("t3_d", 0, 1'b1, 32'h30C, 32'h3, 3'b010, 32'h0);
        quiet("t3_no_fifth", 6);

        // Flush keeps only the committed head.
        push(6'd1, 3'b010, 32'h400, 32'hA1);
        push(6'd2, 3'b010, 32'h404, 32'hA2);
        push(6'd3, 3'b010, 32'h408, 32'hA3);
        commit(6'd1);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        commit(6'd2);
        commit(6'd3);
        do_mem("t4_st", 0, 1'b1, 32'h400, 32'hA1, 3'b010, 32'h0);
        quiet("t4_flushed", 6);
        chk("t4_st_ready", st_ready, 1'b1);

        // Flush during LOAD: transaction completes, result suppressed.
        issue_load("t5_ld_ready", 6'd7, 32'h500);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        do_mem("t5_ld", 1, 1'b0, 32'h500, 32'h0, 3'b010, 32'h1234);
        chk("t5_no_done", ld_done,    1'b0);
        chk("t5_no_rob",  ld_rob_out, NOROB);
        chk("t5_no_data", ld_data,    32'h0);
        tick;
        issue_load("t5_idle_again", 6'd8, 32'h504);
        do_mem("t5_ld2", 0, 1'b0, 32'h504, 32'h0, 3'b010, 32'h5678);
        chk("t5_ld2_done", ld_done,    1'b1);
        chk("t5_ld2_rob",  ld_rob_out, 6'd8);
        chk("t5_ld2_data", ld_data,    32'h5678);
        tick;

        // Reset in the middle of a store; a late ack is ignored.
        push(6'd20, 3'b010, 32'h600, 32'h66);
        commit(6'd20);
        tick;
        chk("t6_busy", mem_req, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        chk("t6_rst_req",   mem_req,    1'b0);
        chk("t6_rst_we",    mem_we,     1'b0);
        chk("t6_rst_addr",  mem_addr,   32'h0);
        chk("t6_rst_wdata", mem_wdata,  32'h0);
        chk("t6_rst_ready", st_ready,   1'b1);
        chk("t6_rst_rob",   ld_rob_out, NOROB);
        chk("t6_rst_done",  ld_done,    1'b0);
        tick;
        reset = 1'b0;
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        quiet("t6_queue_empty", 6);

        // Enqueue and commit of the same tag in one cycle; halfword store.
        st_valid = 1'b1; st_rob = 6'd25; st_type = 3'b001; st_addr = 32'h702; st_data = 32'h77;
        commit_valid = 1'b1; commit_rob = 6'd25;
        tick;
        st_valid = 1'b0; commit_valid = 1'b0;
        do_mem("t7_st", 0, 1'b1, 32'h702, 32'h77, 3'b001, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
